multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle control unit that drives the datapath ALU's 2-bit opcode and operand selects, and consumes the ALU's zero/negative flags to resolve branches. It sequences fetch, decode, execute, memory and writeback for a MIPS-subset core. It sits between the instruction register and the datapath muxes/strobes, with a memory-ready handshake for variable-latency memory.

Parameters:
OP_W, 6, instruction opcode field width
FUNCT_W, 6, R-type funct field width
STATE_W, 4, state register / debug state output width

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_n_i  in  1  synchronous active-low reset
instr_op_i  in  OP_W  opcode field from instruction register
instr_funct_i  in  FUNCT_W  funct field from instruction register
alu_zero_i  in  1  ALU result == 0
alu_negative_i  in  1  ALU result sign bit
mem_ready_i  in  1  memory access completes this cycle
pc_write_o  out  1  PC load strobe
ir_write_o  out  1  instruction register load strobe
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
iord_o  out  1  address select: 0=PC, 1=ALUOut
reg_write_o  out  1  register file write strobe
reg_dst_o  out  1  dest reg: 0=rt, 1=rd
mem_to_reg_o  out  1  writeback data: 0=ALUOut, 1=MDR
alu_src_a_o  out  1  0=PC, 1=reg A
alu_src_b_o  out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
alu_opcode_o  out  2  00=ADD, 01=SUB, 10=AND, 11=OR
pc_src_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
state_o  out  STATE_W  current state (debug)
illegal_o  out  1  high while in TRAP

Behaviour:
- Decision is fact: one clock, synchronous active-low reset. State register loads FETCH on any clock edge with rst_n_i=0, including mid-instruction; no partial writes complete.
- While rst_n_i=0, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) forced 0 combinationally. After reset, all outputs are the FETCH decode. illegal_o=0.
- Outputs are Moore decodes of state; only pc_write_o/ir_write_o gate on mem_ready_i (FETCH) and pc_write_o on flags (BRANCH). Unlisted outputs are 0.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=01, ADD, pc_src=00. ir_write=pc_write=mem_ready_i. Stay until mem_ready_i=1, then go to DECODE.
- DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next state by op:
  - 000000 with funct 100000/100010/100100/100101 -> R_EXEC.
  - 100011 LW, 101011 SW -> MEM_ADDR.
  - 000100 BEQ, 000101 BNE, 000001 BLTZ -> BRANCH.
  - 000010 J -> JUMP.
  - 001000 ADDI -> ADDI_EXEC.
  - Any other op, or R-type with another funct -> TRAP.
- MEM_ADDR: src_a=1, src_b=10, ADD. Go to MEM_RD if op=LW, else MEM_WR.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready_i, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready_i, then FETCH.
- R_EXEC: src_a=1, src_b=00. alu_opcode from funct: ADD 00, SUB 01, AND 10, OR 11. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01. pc_write is:
  - BEQ: alu_zero_i.
  - BNE: ~alu_zero_i.
  - BLTZ: alu_negative_i (rt=$zero).
  Then FETCH.
- JUMP: pc_write=1, pc_src=10. Then FETCH.
- ADDI_EXEC: src_a=1, src_b=10, ADD. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- TRAP: all strobes 0, illegal_o=1. Sticky; left only by reset.
- instr_op_i/instr_funct_i must be stable from DECODE through the end of the instruction; they are sampled combinationally per state.
- Cycle counts with mem_ready_i tied 1: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE/BLTZ 3, J 3. Each memory stall cycle adds 1.

Test Plan:
- Reset then ADD (op 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0. alu_opcode=00 in R_EXEC. reg_write=1 and reg_dst=1 only in R_WB.
- LW with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with mem_read=1, iord=1. Then MEM_WB with mem_to_reg=1. Total 7 cycles.
- BEQ with alu_zero=1 -> pc_write=1, pc_src=01 in BRANCH. Repeat with zero=0 -> pc_write=0. BNE gives the inverse. BLTZ with negative=1 -> pc_write=1.
- FETCH with mem_ready=0 for 3 cycles -> ir_write=pc_write=0, state stays 0. Fourth cycle with ready=1 -> both 1, next state DECODE.
- Op 111111 in DECODE -> TRAP, illegal_o=1, all strobes 0 for 10+ cycles. Then rst_n_i=0 for one edge -> FETCH, illegal_o=0.
- rst_n_i=0 during MEM_WR with mem_ready=0 -> strobes 0 immediately. Next edge state=FETCH, no mem_write pulse afterwards.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS-subset control unit
// Moore decode of the sequencing state; only FETCH and BRANCH strobes look at live inputs.
module multicycle_control_fsm #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [FUNCT_W-1:0] instr_funct_i,
  input  logic               alu_zero_i,
  input  logic               alu_negative_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               ir_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               iord_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_opcode_o,
  output logic [1:0]         pc_src_o,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);

  state_t state;
  state_t state_next;
  logic   funct_legal;

  always_comb begin
    funct_legal = (instr_funct_i == FN_ADD) || (instr_funct_i == FN_SUB) ||
                  (instr_funct_i == FN_AND) || (instr_funct_i == FN_OR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_opcode_o = 2'b00;
    pc_src_o     = 2'b00;
    illegal_o    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b_o = 2'b11;
        case (instr_op_i)
          OP_RTYPE:       state_next = funct_legal ? S_R_EXEC : S_TRAP;
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE,
          OP_BLTZ:        state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          OP_ADDI:        state_next = S_ADDI_EXEC;
          default:        state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_next  = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) state_next = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        case (instr_funct_i)
          FN_SUB:  alu_opcode_o = 2'b01;
          FN_AND:  alu_opcode_o = 2'b10;
          FN_OR:   alu_opcode_o = 2'b11;
          default: alu_opcode_o = 2'b00;
        endcase
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_opcode_o = 2'b01;
        pc_src_o     = 2'b01;
        case (instr_op_i)
          OP_BEQ:  pc_write_o = alu_zero_i;
          OP_BNE:  pc_write_o = ~alu_zero_i;
          OP_BLTZ: pc_write_o = alu_negative_i;
          default: pc_write_o = 1'b0;
        endcase
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        state_next = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_o = 1'b1;
        state_next  = S_FETCH;
      end
      S_TRAP: begin
        illegal_o = 1'b1;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase

    // Reset kills every side effect in the same cycle it is asserted.
    if (!rst_n_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
    end
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
// Table vectors, directed corner sequences and randomized instruction streams.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       neg;
  logic       ready;

  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_opcode, pc_src;
  logic [3:0] state;
  logic [15:0] out_word;
  logic [4:0]  strobes;

  int checks = 0;
  int fails  = 0;
  int path[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OP_W(6), .FUNCT_W(6), .STATE_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .instr_op_i(op), .instr_funct_i(funct),
    .alu_zero_i(zero), .alu_negative_i(neg), .mem_ready_i(ready),
    .pc_write_o(pc_write), .ir_write_o(ir_write), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .iord_o(iord), .reg_write_o(reg_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_opcode_o(alu_opcode), .pc_src_o(pc_src),
    .state_o(state), .illegal_o(illegal)
  );

  assign out_word = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_opcode, pc_src, illegal};
  assign strobes  = {pc_write, ir_write, mem_read, mem_write, reg_write};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic legal_funct(input logic [5:0] f);
    return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25;
  endfunction

  // Spec-level output table per named state number.
  function automatic logic [15:0] exp_word(input int st, input logic [5:0] o, input logic [5:0] f,
                                           input logic rdy, input logic z, input logic n);
    logic pcw, irw, mr, mw, io, rw, rd, m2r, sa, ill;
    logic [1:0] sb, aop, ps;
    {pcw, irw, mr, mw, io, rw, rd, m2r, sa, ill} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; aop = (f == 6'h22) ? 2'd1 : (f == 6'h24) ? 2'd2 : (f == 6'h25) ? 2'd3 : 2'd0; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pcw = (o == 6'h04) ? z : (o == 6'h05) ? ~z : n; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pcw, irw, mr, mw, io, rw, rd, m2r, sa, sb, aop, ps, ill};
  endfunction

  // Sequence of states an instruction visits with no stalls.
  task automatic build_path(input logic [5:0] o, input logic [5:0] f);
    path = '{0, 1};
    case (o)
      6'h00:        if (legal_funct(f)) begin path.push_back(6); path.push_back(7); end
                    else path.push_back(12);
      6'h23:        begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'h2b:        begin path.push_back(2); path.push_back(5); end
      6'h04, 6'h05,
      6'h01:        path.push_back(8);
      6'h02:        path.push_back(9);
      6'h08:        begin path.push_back(10); path.push_back(11); end
      default:      path.push_back(12);
    endcase
  endtask

  task automatic step(input logic rdy, input int exp_st, input string tag);
    ready = rdy;
    #1;
    check({tag, " state"}, 32'(state), 32'(exp_st));
    check({tag, " outputs"}, 32'(out_word), 32'(exp_word(exp_st, op, funct, rdy, zero, neg)));
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input logic n,
                           input int fstall, input int mstall, input string tag);
    int stalls;
    op = o; funct = f; zero = z; neg = n;
    build_path(o, f);
    foreach (path[i]) begin
      stalls = (path[i] == 0) ? fstall : (path[i] == 3 || path[i] == 5) ? mstall : 0;
      for (int k = 0; k <= stalls; k++) begin
        if (path[i] == 0 || path[i] == 3 || path[i] == 5) step(k == stalls, path[i], tag);
        else step(1'($urandom_range(0, 1)), path[i], tag);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    ready = 1'b1;
    #1;
    check({tag, " strobes in reset"}, 32'(strobes), 32'd0);
    @(posedge clk); #1;
    check({tag, " state after reset"}, 32'(state), 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    logic       n;
    int         exp_third;
    int         exp_cycles;
    logic       exp_pcw3;
    logic [1:0] exp_aop3;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cyc;
    int third;
    logic pcw3;
    logic [1:0] aop3;
    logic [5:0] ops[8];
    logic [5:0] fns[4];

    rst_n = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0; neg = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    do_reset("reset");
    step(1'b0, 0, "reset fetch idle");

    vecs = '{
      '{6'h00, 6'h20, 0, 0, 6,  4, 0, 2'd0},
      '{6'h00, 6'h22, 0, 0, 6,  4, 0, 2'd1},
      '{6'h00, 6'h24, 0, 0, 6,  4, 0, 2'd2},
      '{6'h00, 6'h25, 0, 0, 6,  4, 0, 2'd3},
      '{6'h23, 6'h00, 0, 0, 2,  5, 0, 2'd0},
      '{6'h2b, 6'h00, 0, 0, 2,  4, 0, 2'd0},
      '{6'h04, 6'h00, 1, 0, 8,  3, 1, 2'd1},
      '{6'h04, 6'h00, 0, 0, 8,  3, 0, 2'd1},
      '{6'h05, 6'h00, 1, 0, 8,  3, 0, 2'd1},
      '{6'h05, 6'h00, 0, 0, 8,  3, 1, 2'd1},
      '{6'h01, 6'h00, 0, 1, 8,  3, 1, 2'd1},
      '{6'h01, 6'h00, 1, 0, 8,  3, 0, 2'd1},
      '{6'h02, 6'h00, 0, 0, 9,  3, 1, 2'd0},
      '{6'h08, 6'h00, 0, 0, 10, 4, 0, 2'd0}
    };
    foreach (vecs[i]) begin
      op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].z; neg = vecs[i].n; ready = 1'b1;
      cyc = 0; third = -1; pcw3 = 1'b0; aop3 = 2'b00;
      do begin
        #1;
        if (cyc == 2) begin third = int'(state); pcw3 = pc_write; aop3 = alu_opcode; end
        @(posedge clk); #1;
        cyc++;
      end while (state != 4'd0 && cyc < 20);
      check($sformatf("vec%0d third state", i), 32'(third), 32'(vecs[i].exp_third));
      check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      check($sformatf("vec%0d pc_write", i), 32'(pcw3), 32'(vecs[i].exp_pcw3));
      check($sformatf("vec%0d alu_opcode", i), 32'(aop3), 32'(vecs[i].exp_aop3));
    end

    run_instr(6'h00, 6'h20, 0, 0, 3, 0, "add fetch stall");
    run_instr(6'h23, 6'h00, 0, 0, 0, 2, "lw mem stall");
    run_instr(6'h2b, 6'h00, 0, 0, 1, 3, "sw mem stall");

    run_instr(6'h3f, 6'h00, 0, 0, 0, 0, "trap op");
    for (int k = 0; k < 11; k++) step(1'($urandom_range(0, 1)), 12, "trap sticky");
    do_reset("trap reset");
    step(1'b0, 0, "after trap");
    run_instr(6'h00, 6'h2a, 0, 0, 0, 0, "trap funct");
    do_reset("trap2 reset");

    op = 6'h2b; funct = 6'h00;
    step(1'b1, 0, "swrst");
    step(1'b1, 1, "swrst");
    step(1'b1, 2, "swrst");
    ready = 1'b0; #1;
    check("swrst mem_write before reset", 32'(mem_write), 32'd1);
    rst_n = 1'b0; #1;
    check("swrst strobes in reset", 32'(strobes), 32'd0);
    @(posedge clk); #1;
    check("swrst state after reset", 32'(state), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("swrst no mem_write", 32'(mem_write), 32'd0);
      check("swrst fetch held", 32'(state), 32'd0);
      @(posedge clk); #1;
    end

    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h01, 6'h02, 6'h08};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25};
    for (int t = 0; t < 150; t++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, 7)];
      f = fns[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) o = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) f = 6'($urandom_range(0, 63));
      run_instr(o, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      if (path[path.size()-1] == 12) begin
        step(1'b1, 12, "rand trap");
        do_reset("rand reset");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
